// File: rtl/ltl_verdict_collector.sv
// Collects per-property LTL verdict hits into a timestamped event FIFO with saturating counters,
// sticky flags and an interrupt. Define LTL_COLLECT_EDGE_EN to count rising edges instead of levels.
module ltl_verdict_collector #(
  parameter int NUM_PROPS  = 2,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [NUM_PROPS-1:0]       ltl_hits,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [NUM_PROPS-1:0]       evt_mask,
  output logic [TS_W-1:0]            evt_ts,
  output logic [NUM_PROPS*CNT_W-1:0] hit_count,
  output logic [NUM_PROPS-1:0]       sticky,
  output logic                       overflow,
  output logic                       irq
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = NUM_PROPS + TS_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [TS_W-1:0]            ts_r;
  logic [REC_W-1:0]           mem_r [FIFO_DEPTH];
  logic [AW-1:0]              rd_ptr_r;
  logic [AW-1:0]              wr_ptr_r;
  logic [AW:0]                count_r;
  logic                       evt_valid_r;
  logic [NUM_PROPS-1:0]       evt_mask_r;
  logic [TS_W-1:0]            evt_ts_r;
  logic [NUM_PROPS*CNT_W-1:0] cnt_r;
  logic [NUM_PROPS-1:0]       sticky_r;
  logic                       overflow_r;
  logic                       irq_r;
`ifdef LTL_COLLECT_EDGE_EN
  logic [NUM_PROPS-1:0]       prev_r;
`endif

  logic [NUM_PROPS-1:0] h_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 push_ok_s;
  logic                 drop_s;
  logic [REC_W-1:0]     rec_s;
  logic [AW-1:0]        rd_ptr_nxt_s;
  logic [AW:0]          count_nxt_s;
  logic [REC_W-1:0]     head_nxt_s;

  // Qualified hits, FIFO control and the next head record
  always_comb begin
    h_s          = '0;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = '0;
    if (run) begin
`ifdef LTL_COLLECT_EDGE_EN
      h_s = ltl_hits & ~prev_r;
`else
      h_s = ltl_hits;
`endif
    end else begin
      h_s = '0;
    end
    push_s    = |h_s;
    pop_s     = evt_valid_r & evt_ready;
    full_s    = (count_r == FULL_CNT);
    push_ok_s = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    rec_s     = {h_s, ts_r};
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
    // A record written this cycle becomes the head only when nothing older remains
    if (count_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = rec_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Event storage array (data only, validity tracked by count_r)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= rec_s;
    end
  end

  // Timestamp, FIFO pointers and registered head outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r        <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      evt_valid_r <= 1'b0;
      evt_mask_r  <= '0;
      evt_ts_r    <= '0;
    end else begin
      if (run) begin
        ts_r <= ts_r + TS_W'(1);
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      evt_valid_r <= (count_nxt_s != '0);
      evt_mask_r  <= head_nxt_s[REC_W-1:TS_W];
      evt_ts_r    <= head_nxt_s[TS_W-1:0];
    end
  end

  // Saturating counters, sticky flags, overflow and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= '0;
      sticky_r   <= '0;
      overflow_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      irq_r <= (|sticky_r) | overflow_r;
      if (clear) begin
        cnt_r      <= '0;
        sticky_r   <= '0;
        overflow_r <= 1'b0;
      end else begin
        sticky_r <= sticky_r | h_s;
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
        for (int i = 0; i < NUM_PROPS; i++) begin
          if (h_s[i] && (cnt_r[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
            cnt_r[i*CNT_W +: CNT_W] <= cnt_r[i*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef LTL_COLLECT_EDGE_EN
  // Previous run-qualified verdict levels for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= '0;
    end else if (run) begin
      prev_r <= ltl_hits;
    end else begin
      prev_r <= '0;
    end
  end
`endif

  assign evt_valid = evt_valid_r;
  assign evt_mask  = evt_mask_r;
  assign evt_ts    = evt_ts_r;
  assign hit_count = cnt_r;
  assign sticky    = sticky_r;
  assign overflow  = overflow_r;
  assign irq       = irq_r;

endmodule

// File: doc/ltl_verdict_collector.md
Name: ltl_verdict_collector

Overview:
- Downstream consumer of a monitor cluster's per-property verdict lines (ltl0c0, ltl1c0, ...).
- Samples the verdict lines every cycle while run is high and timestamps each cycle that has any hit.
- Queues {mask, timestamp} records in a small FIFO for a valid/ready reader, and keeps per-property saturating hit counters, sticky flags and an interrupt line.

Parameters:
- NUM_PROPS, 2, number of verdict lines from the cluster
- TS_W, 16, timestamp counter width
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2
- CNT_W, 8, width of each per-property hit counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- run  in  1  monitor enable, same signal the cluster receives
- ltl_hits  in  NUM_PROPS  verdict lines; bit i = property i (bit 0 = ltl0c0)
- clear  in  1  synchronous clear of counters, sticky flags and overflow
- evt_valid  out  1  FIFO head is valid
- evt_ready  in  1  reader accepts the head
- evt_mask  out  NUM_PROPS  hit mask of the head record
- evt_ts  out  TS_W  timestamp of the head record
- hit_count  out  NUM_PROPS*CNT_W  counters; property i in bits [i*CNT_W +: CNT_W]
- sticky  out  NUM_PROPS  per-property "has ever hit" flag
- overflow  out  1  sticky flag: at least one record was dropped
- irq  out  1  registered OR of all sticky bits and overflow

Behaviour:
- Reset (synchronous, active-high):
  - Timestamp counter = 0; FIFO empty; all counters = 0.
  - sticky = 0, overflow = 0, irq = 0, evt_valid = 0.
  - evt_mask and evt_ts drive 0 while the FIFO is empty.
- Timestamp: increments by 1 in every cycle with run=1, wraps from 2^TS_W-1 to 0, holds when run=0.
- Qualified hit: h = ltl_hits when run=1, otherwise 0. Cycles with run=0 are ignored entirely.
- Enqueue:
  - A cycle N with h != 0 produces the record {h, ts(N)}, where ts(N) is the counter value before its cycle-N increment.
  - evt_valid rises at N+1 when the FIFO was empty.
  - Records leave in arrival order.
- Handshake:
  - Pop when evt_valid and evt_ready are both high.
  - evt_mask and evt_ts are stable while evt_valid=1 and evt_ready=0.
  - evt_ready while the FIFO is empty has no effect.
- Full FIFO:
  - A push with no pop in the same cycle drops the new record and sets overflow.
  - A push with a pop in the same cycle is accepted and the occupancy stays at FIFO_DEPTH.
- Empty FIFO with a push in the same cycle: no bypass. The record appears at the next cycle.
- Counters:
  - In each cycle, hit_count[i] += h[i], saturating at 2^CNT_W-1 (no wrap).
  - sticky[i] is set when h[i]=1.
- clear:
  - Zeroes all counters, sticky and overflow at the next edge.
  - clear wins over a hit in the same cycle: that hit updates no counter or flag, but is still enqueued.
  - clear does not flush the FIFO or reset the timestamp.
- irq = registered (|sticky | overflow), so it is one cycle behind the flags. A clear drops irq two cycles after clear is asserted.
- Reset mid-operation: FIFO contents are discarded and no partial handshake is completed. evt_valid=0 in the cycle after reset.
- No combinational path from any input to any output except evt_ready to the internal pop enable. All outputs are registered.

Optional Feature:
- Macro: LTL_COLLECT_EDGE_EN.
- When defined:
  - h[i] = run & ltl_hits[i] & ~prev[i], where prev holds the previous cycle's run-qualified ltl_hits.
  - prev resets to 0 and is reloaded every cycle.
  - A verdict line held high records, counts and sets sticky once per assertion.
- When undefined: level mode, where every hit cycle is recorded and counted. prev is not instantiated.

Test Plan:
- Level hit: after reset, run=1 and ltl_hits=2'b01 for 3 cycles at ts 5,6,7, evt_ready=1 → three records (01,5), (01,6), (01,7); hit_count[0]=3, sticky=01; irq rises 2 cycles after the first hit.
- Backpressure and overflow (FIFO_DEPTH=4): evt_ready=0, six hit cycles → 4 records kept (the oldest four) and overflow=1. Then evt_ready=1 → exactly those 4 drain in order.
- Full with simultaneous push and pop: FIFO full, evt_ready=1 and a hit in the same cycle → no overflow; occupancy stays 4; the new record is last out.
- Saturation and clear (CNT_W=8): 300 hit cycles on property 1 → hit_count[1]=255. Then clear together with a hit → count=0, sticky[1]=0, that hit still enqueued, FIFO intact.
- run gating and wrap (TS_W=4): run=0 with ltl_hits=11 → no records, no count, ts frozen. Then run=1 across ts 15→0 → records carry ts 15 then 0.
- Edge mode (LTL_COLLECT_EDGE_EN defined): ltl_hits[0] high for 5 cycles, low 1 cycle, high 2 cycles → exactly 2 records; hit_count[0]=2.
